a2d_scan_ctrl: RTL and testbench
================================

Name: a2d_scan_ctrl

Overview:
- Sequencer that owns one 16-bit SPI master and uses it to run periodic round-robin conversion scans of an 8-channel, 12-bit SPI A2D converter.
- Each channel conversion takes two SPI transactions: the first sends the channel select, the second returns the result.
- Results go out on a one-cycle valid strobe to downstream filter and threshold logic.
- Sits between the SPI master (on wrt/cmd/done/rd_data) and the control datapath.

Parameters:
- SCAN_INTERVAL, 50000: clk cycles from one scan start to the next scan start (minimum 1).
- GAP_CYCLES, 2: idle clk cycles inserted between the two transactions of one conversion (minimum 1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en  input  1  scan enable; level-sensitive
- chnl_mask  input  8  bit i set means channel i is converted in each scan
- spi_wrt  output  1  one-cycle pulse that starts an SPI transaction
- spi_cmd  output  16  command word; valid in the spi_wrt cycle
- spi_done  input  1  SPI master done; high while the master is idle, low during a transaction
- spi_rd_data  input  16  word shifted in by the SPI master
- res_vld  output  1  one-cycle pulse; result is valid
- res_chnl  output  3  channel of the presented result
- res_data  output  12  conversion result
- scan_done  output  1  one-cycle pulse after the last enabled channel of a scan is stored
- busy  output  1  high in every state except IDLE and INTERVAL

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: spi_wrt=0, spi_cmd=16'h0000, res_vld=0, res_chnl=0, res_data=0, scan_done=0, busy=0. State=IDLE, interval counter=0, channel pointer=0.
- Done detection: spi_done is registered each cycle into done_ff. Transaction completion is the rising edge, spi_done & ~done_ff. A high level of spi_done is never treated as completion, because the master holds done high while idle and only clears it the cycle after wrt.
- Command format: spi_cmd = {2'b00, chnl[2:0], 11'h000}. The same cmd is sent on both transactions of a conversion.
- Result: res_data = spi_rd_data[11:0], captured on the completion edge of the second transaction. Bits [15:12] are ignored.
- States:
  - IDLE: if en and chnl_mask != 0, latch chnl_mask into scan_mask, load the interval counter with SCAN_INTERVAL-1, set the pointer to the lowest set bit of scan_mask, and go to CMD1. Otherwise stay in IDLE.
  - CMD1: assert spi_wrt for 1 cycle, then go to WAIT1.
  - WAIT1: wait for the completion edge, then go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to CMD2.
  - CMD2: assert spi_wrt for 1 cycle, then go to WAIT2.
  - WAIT2: on the completion edge, go to STORE.
  - STORE: pulse res_vld with res_chnl=pointer. Advance the pointer to the next higher set bit of scan_mask.
    - If one exists, go to CMD1.
    - If not, pulse scan_done in the same cycle and go to INTERVAL.
  - INTERVAL: wait for the interval counter to reach 0.
    - Then: if en and chnl_mask != 0, re-latch the mask and go to CMD1; otherwise go to IDLE.
- Interval counter: loaded at scan start and decremented every cycle regardless of state. It saturates at 0.
  - If the scan takes longer than SCAN_INTERVAL, the next scan starts immediately after STORE. No scan is skipped or queued.
- en deasserted mid-scan: the current scan completes (all latched channels are stored and scan_done pulses), then the controller goes to IDLE.
- chnl_mask changes mid-scan: ignored until the next scan start.
- Single-bit mask: 1 conversion per scan, scan_done in the same cycle as res_vld.
- Reset mid-transaction: all outputs return to reset values immediately. The SPI master is reset separately by the system.
- Wrap-around: the pointer never wraps inside a scan. Each scan runs ascending from the lowest set bit to the highest.

Optional Feature:
- Macro: A2D_OVERSAMPLE_EN.
- When defined:
  - Each channel is converted 4 times back-to-back (4 × CMD1..WAIT2 sequences, with GAP between each pair).
  - The four 12-bit results are summed in a 14-bit accumulator, cleared at the channel's first conversion.
  - res_data = acc[13:2] (truncating divide by 4). One res_vld per channel.
- When undefined: a single conversion per channel, and no accumulator or 2-bit repeat counter is present in the RTL.

Test Plan:
- en=1, chnl_mask=8'h05, SCAN_INTERVAL=2000, SPI model returns 16'hF123 for ch0 and 16'h0ABC for ch2:
  - spi_cmd sequence 16'h0000, 16'h0000, 16'h1000, 16'h1000.
  - res_vld twice: (0, 12'h123), then (2, 12'hABC).
  - scan_done with the second res_vld; next spi_wrt exactly 2000 cycles after the first.
- Idle master with spi_done held high: no completion before the falling-then-rising edge; GAP between the two wrt pulses is ≥ GAP_CYCLES.
- chnl_mask=8'h80, SCAN_INTERVAL=10 (shorter than one conversion): next scan starts in the cycle after STORE, with cmd 16'h3800.
- Change chnl_mask from 8'h03 to 8'h10 mid-scan and drop en: ch0 and ch1 are stored, scan_done pulses, then IDLE with busy=0.
- Assert rst during WAIT1: spi_wrt, res_vld and busy go to 0 asynchronously. After release, with en=1, the first spi_wrt occurs with the lowest-channel cmd.
- With A2D_OVERSAMPLE_EN, ch3 returns 12'h100, 12'h101, 12'h102, 12'h103: 8 spi_wrt pulses, then one res_vld with (3, 12'h101).

Source files
------------

// File: rtl/a2d_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : a2d_scan_ctrl
// Description : Round-robin scan sequencer for an 8-channel, 12-bit SPI A2D.
//               Each conversion is two SPI transactions: the first selects the
//               channel and the second returns the result. Results go out on
//               a one-cycle res_vld strobe. Scans repeat every SCAN_INTERVAL
//               clocks.
//               Optional macro A2D_OVERSAMPLE_EN: convert each channel four
//               times and present the truncated average.
// Revision    : 1.0 - initial release
// ============================================================================
module a2d_scan_ctrl #(
    parameter int SCAN_INTERVAL = 50000,
    parameter int GAP_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  chnl_mask,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        res_vld,
    output logic [2:0]  res_chnl,
    output logic [11:0] res_data,
    output logic        scan_done,
    output logic        busy
);

    localparam int CNT_W = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INTERVAL_LOAD = CNT_W'(SCAN_INTERVAL - 1);
    localparam logic [GAP_W-1:0] GAP_LAST      = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD1     = 3'd1,
        S_WAIT1    = 3'd2,
        S_GAP      = 3'd3,
        S_CMD2     = 3'd4,
        S_WAIT2    = 3'd5,
        S_STORE    = 3'd6,
        S_INTERVAL = 3'd7
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             done_ff;
    logic             done_rise;
    logic             scan_start;
    logic [7:0]       scan_mask;
    logic [7:0]       higher_mask;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] ivl_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_conv;
    logic             unused_rd_hi;

    // Index of the lowest set bit; callers only use it on non-zero masks.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // The master idles with done high, so only a 0->1 transition marks completion.
    assign done_rise   = spi_done & ~done_ff;
    // Channels of the latched mask strictly above the current pointer.
    assign higher_mask = scan_mask & ~(8'hFF >> (3'd7 - ptr));
    // Result bits [15:12] carry no conversion data.
    assign unused_rd_hi = ^spi_rd_data[15:12];

    assign spi_wrt   = (state == S_CMD1) || (state == S_CMD2);
    assign spi_cmd   = {2'b00, ptr, 11'h000};
    assign res_vld   = (state == S_STORE);
    assign res_chnl  = ptr;
    assign scan_done = (state == S_STORE) && (higher_mask == 8'h00);
    assign busy      = (state != S_IDLE) && (state != S_INTERVAL);

`ifdef A2D_OVERSAMPLE_EN
    logic [1:0]  rep_cnt;
    logic [13:0] acc;

    assign last_conv = (rep_cnt == 2'd3);
    assign res_data  = acc[13:2];

    // Accumulate four conversions per channel; the first one overwrites the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= 2'd0;
            acc     <= 14'd0;
        end else if (state == S_WAIT2 && done_rise) begin
            rep_cnt <= rep_cnt + 2'd1;
            if (rep_cnt == 2'd0) acc <= {2'b00, spi_rd_data[11:0]};
            else                 acc <= acc + {2'b00, spi_rd_data[11:0]};
        end
    end
`else
    logic [11:0] res_q;

    assign last_conv = 1'b1;
    assign res_data  = res_q;

    // Capture the result word on completion of the second transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                res_q <= 12'd0;
        else if (state == S_WAIT2 && done_rise) res_q <= spi_rd_data[11:0];
    end
`endif

    // Next-state decode; scan_start marks the cycle that latches a new scan.
    always_comb begin
        state_nxt  = state;
        scan_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && chnl_mask != 8'h00) begin
                    scan_start = 1'b1;
                    state_nxt  = S_CMD1;
                end
            end
            S_CMD1:  state_nxt = S_WAIT1;
            S_WAIT1: if (done_rise) state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_CMD2;
            S_CMD2:  state_nxt = S_WAIT2;
            S_WAIT2: if (done_rise) state_nxt = last_conv ? S_STORE : S_CMD1;
            S_STORE: state_nxt = (higher_mask != 8'h00) ? S_CMD1 : S_INTERVAL;
            S_INTERVAL: begin
                if (ivl_cnt == '0) begin
                    if (en && chnl_mask != 8'h00) begin
                        scan_start = 1'b1;
                        state_nxt  = S_CMD1;
                    end else begin
                        state_nxt  = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Delayed copy of spi_done for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_ff <= 1'b1;
        else     done_ff <= spi_done;
    end

    // Scan period counter: loaded at scan start, free-running down, saturating at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 ivl_cnt <= '0;
        else if (scan_start)     ivl_cnt <= INTERVAL_LOAD;
        else if (ivl_cnt != '0)  ivl_cnt <= ivl_cnt - 1'b1;
    end

    // Mask latch and ascending channel pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_mask <= 8'h00;
            ptr       <= 3'd0;
        end else if (scan_start) begin
            scan_mask <= chnl_mask;
            ptr       <= lowest_set(chnl_mask);
        end else if (state == S_STORE && higher_mask != 8'h00) begin
            ptr       <= lowest_set(higher_mask);
        end
    end

    // Counts the idle cycles spent in GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 gap_cnt <= '0;
        else if (state != S_GAP) gap_cnt <= '0;
        else                     gap_cnt <= gap_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_a2d_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_a2d_scan_ctrl
// Description : Directed self-checking bench for a2d_scan_ctrl with a
//               behavioural SPI master responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a2d_scan_ctrl;

    localparam int SCAN_INTERVAL = 2000;
    localparam int GAP_CYCLES    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  chnl_mask = 8'h00;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done = 1'b1;
    logic [15:0] spi_rd_data = 16'h0000;
    logic        res_vld;
    logic [2:0]  res_chnl;
    logic [11:0] res_data;
    logic        scan_done;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    a2d_scan_ctrl #(
        .SCAN_INTERVAL(SCAN_INTERVAL),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .chnl_mask  (chnl_mask),
        .spi_wrt    (spi_wrt),
        .spi_cmd    (spi_cmd),
        .spi_done   (spi_done),
        .spi_rd_data(spi_rd_data),
        .res_vld    (res_vld),
        .res_chnl   (res_chnl),
        .res_data   (res_data),
        .scan_done  (scan_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI master model: after a wrt, done stays high for hold_hi cycles,
    // then low for xfer_len cycles, then rises with the channel's response.
    int          xfer_len = 10;
    int          hold_hi  = 0;
    bit          add_idx  = 1'b0;
    int          xfer_n   = 0;
    logic [15:0] resp [8];
    int          m_hold, m_low;
    bit          m_active = 1'b0;
    logic [2:0]  m_ch;

    always @(negedge clk) begin
        if (rst) begin
            spi_done = 1'b1;
            m_active = 1'b0;
        end else if (spi_wrt) begin
            m_active = 1'b1;
            m_hold   = hold_hi;
            m_low    = xfer_len;
            m_ch     = spi_cmd[13:11];
            if (hold_hi == 0) spi_done = 1'b0;
        end else if (m_active) begin
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) spi_done = 1'b0;
            end else begin
                m_low--;
                if (m_low == 0) begin
                    spi_done    = 1'b1;
                    spi_rd_data = resp[m_ch] + (add_idx ? 16'((xfer_n / 2) % 4) : 16'd0);
                    xfer_n++;
                    m_active    = 1'b0;
                end
            end
        end
    end

    // Event monitor sampled on the falling edge.
    int          wrt_cyc [$];
    logic [15:0] wrt_cmd [$];
    int          vld_cyc [$];
    logic [2:0]  vld_ch  [$];
    logic [11:0] vld_dat [$];
    logic        vld_sd  [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (spi_wrt) begin
                wrt_cyc.push_back(cyc);
                wrt_cmd.push_back(spi_cmd);
            end
            if (res_vld) begin
                vld_cyc.push_back(cyc);
                vld_ch.push_back(res_chnl);
                vld_dat.push_back(res_data);
                vld_sd.push_back(scan_done);
            end
        end
    end

    task automatic clear_log();
        wrt_cyc.delete(); wrt_cmd.delete();
        vld_cyc.delete(); vld_ch.delete(); vld_dat.delete(); vld_sd.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; chnl_mask = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++; if (spi_wrt   !== 1'b0)     begin errors++; $display("FAIL reset_spi_wrt: got %b expected 0", spi_wrt); end
        checks++; if (spi_cmd   !== 16'h0000) begin errors++; $display("FAIL reset_spi_cmd: got %h expected 0000", spi_cmd); end
        checks++; if (res_vld   !== 1'b0)     begin errors++; $display("FAIL reset_res_vld: got %b expected 0", res_vld); end
        checks++; if (res_chnl  !== 3'd0)     begin errors++; $display("FAIL reset_res_chnl: got %0d expected 0", res_chnl); end
        checks++; if (res_data  !== 12'h000)  begin errors++; $display("FAIL reset_res_data: got %h expected 000", res_data); end
        checks++; if (scan_done !== 1'b0)     begin errors++; $display("FAIL reset_scan_done: got %b expected 0", scan_done); end
        checks++; if (busy      !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic_scan();
        int k;
        logic [15:0] exp_cmd [4];
        exp_cmd = '{16'h0000, 16'h0000, 16'h1000, 16'h1000};
        hold_hi = 0; xfer_len = 10;
        resp[0] = 16'hF123; resp[2] = 16'h0ABC;
        apply_reset();
        en = 1'b1; chnl_mask = 8'h05;
        k = 0;
        while (wrt_cyc.size() < 5 && k < 2600) begin @(posedge clk); k++; end
        checks++; if (wrt_cyc.size() < 5) begin errors++; $display("FAIL basic_timeout: got %0d wrt expected 5", wrt_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wrt_cmd[i] !== exp_cmd[i]) begin errors++; $display("FAIL basic_cmd%0d: got %h expected %h", i, wrt_cmd[i], exp_cmd[i]); end
        end
        // wrt, L low cycles, completion seen, GAP_CYCLES idle, then wrt
        checks++; if (wrt_cyc[1] - wrt_cyc[0] !== 10 + 1 + GAP_CYCLES) begin errors++; $display("FAIL basic_gap: got %0d expected %0d", wrt_cyc[1] - wrt_cyc[0], 13); end
        checks++; if (vld_cyc.size() !== 2) begin errors++; $display("FAIL basic_vld_count: got %0d expected 2", vld_cyc.size()); end
        checks++; if (vld_ch[0]  !== 3'd0)    begin errors++; $display("FAIL basic_ch0: got %0d expected 0", vld_ch[0]); end
        checks++; if (vld_dat[0] !== 12'h123) begin errors++; $display("FAIL basic_dat0: got %h expected 123", vld_dat[0]); end
        checks++; if (vld_sd[0]  !== 1'b0)    begin errors++; $display("FAIL basic_sd0: got %b expected 0", vld_sd[0]); end
        checks++; if (vld_ch[1]  !== 3'd2)    begin errors++; $display("FAIL basic_ch1: got %0d expected 2", vld_ch[1]); end
        checks++; if (vld_dat[1] !== 12'hABC) begin errors++; $display("FAIL basic_dat1: got %h expected abc", vld_dat[1]); end
        checks++; if (vld_sd[1]  !== 1'b1)    begin errors++; $display("FAIL basic_sd1: got %b expected 1", vld_sd[1]); end
        checks++; if (wrt_cyc[4] - wrt_cyc[0] !== SCAN_INTERVAL) begin errors++; $display("FAIL basic_interval: got %0d expected %0d", wrt_cyc[4] - wrt_cyc[0], SCAN_INTERVAL); end
        checks++; if (wrt_cmd[4] !== 16'h0000) begin errors++; $display("FAIL basic_cmd4: got %h expected 0000", wrt_cmd[4]); end
    endtask

    task automatic test_idle_master();
        int k;
        hold_hi = 6; xfer_len = 8;
        resp[1] = 16'h0456;
        apply_reset();
        en = 1'b1; chnl_mask = 8'h02;
        k = 0;
        while (vld_cyc.size() < 1 && k < 500) begin @(posedge clk); k++; end
        checks++; if (vld_cyc.size() < 1) begin errors++; $display("FAIL idle_timeout: got %0d vld expected 1", vld_cyc.size()); end
        // 6 cycles still high, 8 low, completion, 2 gap cycles
        checks++; if (wrt_cyc[1] - wrt_cyc[0] !== 6 + 8 + 1 + GAP_CYCLES) begin errors++; $display("FAIL idle_gap: got %0d expected %0d", wrt_cyc[1] - wrt_cyc[0], 17); end
        checks++; if (vld_dat[0] !== 12'h456) begin errors++; $display("FAIL idle_dat: got %h expected 456", vld_dat[0]); end
        checks++; if (vld_sd[0] !== 1'b1) begin errors++; $display("FAIL idle_sd: got %b expected 1", vld_sd[0]); end
        hold_hi = 0;
    endtask

    task automatic test_late_interval();
        int k;
        hold_hi = 0; xfer_len = 1100;
        resp[7] = 16'h7555;
        apply_reset();
        en = 1'b1; chnl_mask = 8'h80;
        k = 0;
        while (wrt_cyc.size() < 3 && k < 6000) begin @(posedge clk); k++; end
        checks++; if (wrt_cyc.size() < 3) begin errors++; $display("FAIL late_timeout: got %0d wrt expected 3", wrt_cyc.size()); end
        checks++; if (wrt_cmd[0] !== 16'h3800) begin errors++; $display("FAIL late_cmd0: got %h expected 3800", wrt_cmd[0]); end
        checks++; if (vld_ch[0]  !== 3'd7)     begin errors++; $display("FAIL late_ch: got %0d expected 7", vld_ch[0]); end
        checks++; if (vld_dat[0] !== 12'h555)  begin errors++; $display("FAIL late_dat: got %h expected 555", vld_dat[0]); end
        checks++; if (vld_sd[0]  !== 1'b1)     begin errors++; $display("FAIL late_sd: got %b expected 1", vld_sd[0]); end
        // STORE, then INTERVAL with an expired counter restarts, then CMD1
        checks++; if (wrt_cyc[2] - vld_cyc[0] !== 2) begin errors++; $display("FAIL late_restart: got %0d expected 2", wrt_cyc[2] - vld_cyc[0]); end
        checks++; if (wrt_cmd[2] !== 16'h3800) begin errors++; $display("FAIL late_cmd2: got %h expected 3800", wrt_cmd[2]); end
        xfer_len = 10;
    endtask

    task automatic test_mask_change();
        int k;
        hold_hi = 0; xfer_len = 10;
        resp[0] = 16'hF123; resp[1] = 16'h0777;
        apply_reset();
        en = 1'b1; chnl_mask = 8'h03;
        k = 0;
        while (wrt_cyc.size() < 1 && k < 100) begin @(posedge clk); k++; end
        @(negedge clk);
        chnl_mask = 8'h10; en = 1'b0;
        k = 0;
        while (vld_cyc.size() < 2 && k < 500) begin @(posedge clk); k++; end
        checks++; if (vld_cyc.size() < 2) begin errors++; $display("FAIL mask_timeout: got %0d vld expected 2", vld_cyc.size()); end
        checks++; if (vld_ch[0]  !== 3'd0)    begin errors++; $display("FAIL mask_ch0: got %0d expected 0", vld_ch[0]); end
        checks++; if (vld_ch[1]  !== 3'd1)    begin errors++; $display("FAIL mask_ch1: got %0d expected 1", vld_ch[1]); end
        checks++; if (vld_dat[1] !== 12'h777) begin errors++; $display("FAIL mask_dat1: got %h expected 777", vld_dat[1]); end
        checks++; if (vld_sd[1]  !== 1'b1)    begin errors++; $display("FAIL mask_sd: got %b expected 1", vld_sd[1]); end
        checks++; if (wrt_cmd[2] !== 16'h0800) begin errors++; $display("FAIL mask_cmd2: got %h expected 0800", wrt_cmd[2]); end
        repeat (2100) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mask_busy: got %b expected 0", busy); end
        checks++; if (wrt_cyc.size() !== 4) begin errors++; $display("FAIL mask_no_rescan: got %0d wrt expected 4", wrt_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        int k;
        hold_hi = 0; xfer_len = 10;
        apply_reset();
        en = 1'b1; chnl_mask = 8'h0C;
        k = 0;
        while (wrt_cyc.size() < 1 && k < 100) begin @(posedge clk); k++; end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (spi_wrt !== 1'b0)     begin errors++; $display("FAIL rstmid_wrt: got %b expected 0", spi_wrt); end
        checks++; if (res_vld !== 1'b0)     begin errors++; $display("FAIL rstmid_vld: got %b expected 0", res_vld); end
        checks++; if (busy    !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (spi_cmd !== 16'h0000) begin errors++; $display("FAIL rstmid_cmd: got %h expected 0000", spi_cmd); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        k = 0;
        while (wrt_cyc.size() < 1 && k < 100) begin @(posedge clk); k++; end
        checks++; if (wrt_cyc.size() < 1) begin errors++; $display("FAIL rstmid_timeout: got %0d wrt expected 1", wrt_cyc.size()); end
        checks++; if (wrt_cmd[0] !== 16'h1000) begin errors++; $display("FAIL rstmid_first_cmd: got %h expected 1000", wrt_cmd[0]); end
    endtask

`ifdef A2D_OVERSAMPLE_EN
    task automatic test_oversample();
        int k;
        hold_hi = 0; xfer_len = 10;
        resp[3] = 16'h0100;
        apply_reset();
        add_idx = 1'b1; xfer_n = 0;
        en = 1'b1; chnl_mask = 8'h08;
        k = 0;
        while (vld_cyc.size() < 1 && k < 1000) begin @(posedge clk); k++; end
        checks++; if (vld_cyc.size() < 1) begin errors++; $display("FAIL ovs_timeout: got %0d vld expected 1", vld_cyc.size()); end
        checks++; if (wrt_cyc.size() !== 8) begin errors++; $display("FAIL ovs_wrt_count: got %0d expected 8", wrt_cyc.size()); end
        checks++; if (vld_ch[0]  !== 3'd3)    begin errors++; $display("FAIL ovs_ch: got %0d expected 3", vld_ch[0]); end
        checks++; if (vld_dat[0] !== 12'h101) begin errors++; $display("FAIL ovs_dat: got %h expected 101", vld_dat[0]); end
        add_idx = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) resp[i] = 16'h0000;
        test_reset();
`ifndef A2D_OVERSAMPLE_EN
        test_basic_scan();
        test_idle_master();
        test_late_interval();
        test_mask_change();
`endif
        test_reset_mid();
`ifdef A2D_OVERSAMPLE_EN
        test_oversample();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
